// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the generic inter-stage register.
//   - pipe_state_e     : occupancy state of a pipe_stage_skid instance
//   - PIPE_LANES_DEF   : default number of issue lanes
//   - PIPE_DATA_W_DEF  : default payload width per lane
//   - PIPE_NOP_PAYLOAD : NOP fill bit; a squashed or gated lane is all copies of it
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int PIPE_LANES_DEF  = 2;
  localparam int PIPE_DATA_W_DEF = 128;

  // Width-agnostic: replicate to whatever lane/entry width is needed.
  localparam logic PIPE_NOP_PAYLOAD = 1'b0;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// pipe_slot: one storage slot of the skid stage (valid, lane_valid, payload).
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   clr               zero the slot (takes priority over load)
//   load              capture ld_lane_valid / ld_data, marking the slot valid
//   ld_lane_valid     per-lane valid of the incoming entry
//   ld_data           incoming payload, lane i at [i*DATA_W +: DATA_W]
//   vld, lane_vld, data  registered slot contents
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int LANES  = PIPE_LANES_DEF,
  parameter int DATA_W = PIPE_DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    load,
  input  logic [LANES-1:0]        ld_lane_valid,
  input  logic [LANES*DATA_W-1:0] ld_data,
  output logic                    vld,
  output logic [LANES-1:0]        lane_vld,
  output logic [LANES*DATA_W-1:0] data
);

  logic [LANES*DATA_W-1:0] gated_data;

  // Invalid lanes are stored as NOP so nothing stale leaks downstream.
  always_comb begin
    gated_data = ld_data;
    for (int i = 0; i < LANES; i++) begin
      if (!ld_lane_valid[i]) begin
        gated_data[i*DATA_W +: DATA_W] = {DATA_W{PIPE_NOP_PAYLOAD}};
      end
    end
  end

  // Slot register stage
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld      <= 1'b0;
      lane_vld <= '0;
      data     <= {(LANES*DATA_W){PIPE_NOP_PAYLOAD}};
    end else if (load) begin
      vld      <= 1'b1;
      lane_vld <= ld_lane_valid;
      data     <= gated_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready inter-stage register with a 2-entry
// skid buffer so up_ready is a pure flop output.
// Ports:
//   clk, rst                 clock / synchronous active-high reset
//   flush                    squash both held entries (next cycle EMPTY)
//   up_valid, up_lane_valid, up_data   upstream offer
//   up_ready                 registered; low only while both slots are full
//   dn_valid, dn_lane_valid, dn_data   presented entry (main slot)
//   dn_ready                 downstream accept
// Optional (macro PIPE_STAGE_PERF_CNT_EN):
//   perf_stall_cnt           saturating count of dn_valid && !dn_ready cycles
//   perf_bubble_cnt          saturating count of cycles with no useful lane out
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int LANES  = PIPE_LANES_DEF,
  parameter int DATA_W = PIPE_DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    up_valid,
  input  logic [LANES-1:0]        up_lane_valid,
  input  logic [LANES*DATA_W-1:0] up_data,
  output logic                    up_ready,
  output logic                    dn_valid,
  output logic [LANES-1:0]        dn_lane_valid,
  output logic [LANES*DATA_W-1:0] dn_data,
  input  logic                    dn_ready
`ifdef PIPE_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_bubble_cnt
`endif
);

  pipe_state_e state_p0;
  pipe_state_e state_d;

  logic                    up_xfer;
  logic                    dn_xfer;
  logic                    main_load;
  logic                    main_clr;
  logic                    main_from_skid;
  logic                    skid_load;
  logic                    skid_clr;
  logic                    skid_vld;
  logic [LANES-1:0]        skid_lane_vld;
  logic [LANES*DATA_W-1:0] skid_data;
  logic [LANES-1:0]        main_src_lane_vld;
  logic [LANES*DATA_W-1:0] main_src_data;

  assign up_xfer = up_valid && up_ready;
  assign dn_xfer = dn_valid && dn_ready;

  // Occupancy control; flush overrides any handshake in the same cycle.
  always_comb begin
    state_d        = state_p0;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (up_xfer) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (up_xfer && dn_xfer) begin
            main_load = 1'b1;
          end else if (up_xfer) begin
            skid_load = 1'b1;
            state_d   = TWO;
          end else if (dn_xfer) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        TWO: begin
          // up_ready is low here, so only the drain path can fire.
          if (dn_xfer) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_src_lane_vld = main_from_skid ? skid_lane_vld : up_lane_valid;
  assign main_src_data     = main_from_skid ? skid_data     : up_data;

  // Control register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= EMPTY;
      up_ready <= 1'b1;
    end else begin
      state_p0 <= state_d;
      up_ready <= (state_d != TWO);
    end
  end

  pipe_slot #(.LANES(LANES), .DATA_W(DATA_W)) u_main (
    .clk           (clk),
    .rst           (rst),
    .clr           (main_clr),
    .load          (main_load),
    .ld_lane_valid (main_src_lane_vld),
    .ld_data       (main_src_data),
    .vld           (dn_valid),
    .lane_vld      (dn_lane_valid),
    .data          (dn_data)
  );

  pipe_slot #(.LANES(LANES), .DATA_W(DATA_W)) u_skid (
    .clk           (clk),
    .rst           (rst),
    .clr           (skid_clr),
    .load          (skid_load),
    .ld_lane_valid (up_lane_valid),
    .ld_data       (up_data),
    .vld           (skid_vld),
    .lane_vld      (skid_lane_vld),
    .data          (skid_data)
  );

`ifdef PIPE_STAGE_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  // Counter register stage; flush intentionally leaves the counts intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (dn_valid && !dn_ready) begin
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      end
      if (!dn_valid || (dn_lane_valid == '0)) begin
        perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int LANES  = 2;
  localparam int DATA_W = 128;
  localparam int W      = LANES * DATA_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                up_valid;
  logic [LANES-1:0]    up_lane_valid;
  logic [W-1:0]        up_data;
  logic                up_ready;
  logic                dn_valid;
  logic [LANES-1:0]    dn_lane_valid;
  logic [W-1:0]        dn_data;
  logic                dn_ready;
`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0]         perf_stall_cnt;
  logic [31:0]         perf_bubble_cnt;
`endif

  int nvec  = 0;
  int nfail = 0;

  logic [LANES+W-1:0]  sb[$];
  logic                hold_chk = 1'b0;
  logic [W-1:0]        hold_data;
  logic [LANES-1:0]    hold_lv;

  always #5 clk = ~clk;

  pipe_stage_skid #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .up_valid      (up_valid),
    .up_lane_valid (up_lane_valid),
    .up_data       (up_data),
    .up_ready      (up_ready),
    .dn_valid      (dn_valid),
    .dn_lane_valid (dn_lane_valid),
    .dn_data       (dn_data),
    .dn_ready      (dn_ready)
`ifdef PIPE_STAGE_PERF_CNT_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gate(input logic [LANES-1:0] lv, input logic [W-1:0] d);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < LANES; i++) if (!lv[i]) r[i*DATA_W +: DATA_W] = '0;
    return r;
  endfunction

  function automatic logic [W-1:0] mk(input int lane1, input int lane0);
    return {DATA_W'(lane1), DATA_W'(lane0)};
  endfunction

  // Scoreboard monitor: push accepted upstream entries, pop on downstream transfer.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("hold_data", 512'(dn_data), 512'(hold_data));
        chk("hold_lane_valid", 512'(dn_lane_valid), 512'(hold_lv));
      end
      if (dn_valid && dn_ready) begin
        if (sb.size() == 0) begin
          chk("dn_unexpected_entry", 512'(dn_data), 512'(0));
          if (dn_data == '0) begin
            nfail++;
            $display("FAIL dn_unexpected_entry: got zero entry expected none");
          end
        end else begin
          logic [LANES+W-1:0] e;
          e = sb.pop_front();
          chk("dn_data", 512'(dn_data), 512'(e[W-1:0]));
          chk("dn_lane_valid", 512'(dn_lane_valid), 512'(e[LANES+W-1:W]));
        end
      end
      if (up_valid && up_ready)
        sb.push_back({up_lane_valid, gate(up_lane_valid, up_data)});
      hold_chk  = dn_valid && !dn_ready;
      hold_data = dn_data;
      hold_lv   = dn_lane_valid;
    end
  end

  task automatic send(input logic [LANES-1:0] lv, input logic [W-1:0] d, output int retries);
    @(posedge clk); #1;
    up_valid = 1'b1; up_lane_valid = lv; up_data = d;
    retries = 0;
    @(negedge clk);
    while (!up_ready && retries < 50) begin
      @(posedge clk); @(negedge clk);
      retries++;
    end
    if (!up_ready) begin
      nvec++; nfail++;
      $display("FAIL send_timeout: up_ready stuck at 0 after %0d cycles, expected 1", retries);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    up_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b1; flush = 1'b0; dn_ready = 1'b0;
    up_valid = 1'b1; up_lane_valid = '1; up_data = {(W/8){8'hA5}};

    // Reset with an upstream offer present
    repeat (2) begin
      @(negedge clk);
      chk("rst_dn_valid", 512'(dn_valid), 512'(0));
      chk("rst_dn_data", 512'(dn_data), 512'(0));
      chk("rst_up_ready", 512'(up_ready), 512'(1));
    end
    @(posedge clk); #1;
    rst = 1'b0; up_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_dn_valid", 512'(dn_valid), 512'(0));
    chk("post_rst_up_ready", 512'(up_ready), 512'(1));

    // Streaming 1..8 at full throughput
    dn_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(2'b11, mk(k + 100, k), r);
      chk("stream_retries", 512'(r), 512'(0));
      if (k > 1) begin
        chk("stream_dn_valid", 512'(dn_valid), 512'(1));
        chk("stream_dn_lane0", 512'(dn_data[DATA_W-1:0]), 512'(k - 1));
      end
    end
    idle();
    repeat (3) @(posedge clk);

    // Backpressure: 1 on dn, 2 in skid, 3 waits upstream
    #1 dn_ready = 1'b0;
    send(2'b11, mk(201, 1), r);
    send(2'b11, mk(202, 2), r);
    chk("bp_second_accept", 512'(r), 512'(0));
    @(posedge clk); #1;
    up_valid = 1'b1; up_lane_valid = 2'b11; up_data = mk(203, 3);
    @(negedge clk);
    chk("bp_up_ready_low", 512'(up_ready), 512'(0));
    chk("bp_dn_holds_1", 512'(dn_data[DATA_W-1:0]), 512'(1));
    @(posedge clk); #1;
    dn_ready = 1'b1;
    @(negedge clk);
    chk("bp_up_ready_still_low", 512'(up_ready), 512'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_up_ready_back", 512'(up_ready), 512'(1));
    idle();
    repeat (3) @(posedge clk);

    // Lane gating and an all-invalid bubble
    send(2'b01, {{DATA_W{1'b1}}, DATA_W'(32'h1234)}, r);
    send(2'b00, mk(77, 55), r);
    chk("gate_lane_valid", 512'(dn_lane_valid), 512'(2'b01));
    chk("gate_lane1_zero", 512'(dn_data[W-1:DATA_W]), 512'(0));
    chk("gate_lane0", 512'(dn_data[DATA_W-1:0]), 512'(32'h1234));
    idle();
    @(negedge clk);
    chk("bubble_dn_valid", 512'(dn_valid), 512'(1));
    chk("bubble_lane_valid", 512'(dn_lane_valid), 512'(0));
    repeat (3) @(posedge clk);

    // Flush while TWO with simultaneous up_valid and dn_ready
    #1 dn_ready = 1'b0;
    send(2'b11, mk(301, 11), r);
    send(2'b11, mk(302, 12), r);
    @(posedge clk); #1;
    flush = 1'b1; dn_ready = 1'b1;
    up_valid = 1'b1; up_lane_valid = 2'b11; up_data = mk(303, 13);
    @(posedge clk); #1;
    flush = 1'b0; up_valid = 1'b0;
    @(negedge clk);
    chk("flush_dn_valid", 512'(dn_valid), 512'(0));
    chk("flush_up_ready", 512'(up_ready), 512'(1));
    chk("flush_dn_data", 512'(dn_data), 512'(0));
    repeat (4) @(negedge clk);
    send(2'b11, mk(304, 14), r);
    idle();
    repeat (3) @(posedge clk);

    // Reset mid-operation
    #1 dn_ready = 1'b0;
    send(2'b11, mk(401, 21), r);
    send(2'b11, mk(402, 22), r);
    @(posedge clk); #1;
    up_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_dn_valid", 512'(dn_valid), 512'(0));
    chk("midrst_up_ready", 512'(up_ready), 512'(1));
    dn_ready = 1'b1;

`ifdef PIPE_STAGE_PERF_CNT_EN
    begin
      logic [31:0] base;
      send(2'b11, mk(501, 31), r);
      @(posedge clk); #1;
      up_valid = 1'b0; dn_ready = 1'b0;
      @(negedge clk);
      base = perf_stall_cnt;
      repeat (5) @(posedge clk);
      #1 chk("perf_stall_5", 512'(perf_stall_cnt - base), 512'(5));
      dut.perf_stall_cnt = 32'hFFFF_FFFE;
      repeat (3) @(posedge clk);
      #1 chk("perf_stall_sat", 512'(perf_stall_cnt), 512'(32'hFFFF_FFFF));
      dn_ready = 1'b1;
    end
`endif

    repeat (5) @(negedge clk);
    chk("sb_drained", 512'(sb.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
